// File: rtl/rib_master_arb_pkg.sv
// Shared constants for the RIB master arbiter.
// State encodings, counter width and master slot indices.
package rib_master_arb_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RibTimeoutW = 8;

  localparam logic [1:0] RibIdle = 2'd0;
  localparam logic [1:0] RibBusy = 2'd1;
  localparam logic [1:0] RibDone = 2'd2;

  localparam int unsigned MstJtag    = 0;
  localparam int unsigned MstCoreEx  = 1;
  localparam int unsigned MstUartDbg = 2;
  localparam int unsigned MstCorePc  = 3;

endpackage

// File: rtl/rib_prio_enc.sv
// Lowest-index-first one-hot priority encoder.
// Isolates the least significant set request bit.
module rib_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         vld_o
);

  assign gnt_o = req_i & (~req_i + N'(1));
  assign vld_o = |req_i;

endmodule

// File: rtl/rib_master_arb.sv
// RIB master arbiter: fixed-priority grant of one master onto the slave port.
// Returns slave data with an ack pulse, times out hung transfers, drives core hold.
module rib_master_arb
  import rib_master_arb_pkg::*;
#(
  parameter int unsigned      NUM_M       = 4,
  parameter int unsigned      TIMEOUT_CYC = 255,
  parameter logic [NUM_M-1:0] HOLD_MASK   = 4'b0101
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_M-1:0]       m_req_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [NUM_M*DataW-1:0] m_addr_i,
  input  logic [NUM_M*DataW-1:0] m_wdata_i,
  output logic [DataW-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic                   m_err_o,
  output logic [NUM_M-1:0]       grant_o,
  output logic                   s_req_o,
  output logic                   s_we_o,
  output logic [DataW-1:0]       s_addr_o,
  output logic [DataW-1:0]       s_wdata_o,
  input  logic [DataW-1:0]       s_rdata_i,
  input  logic                   s_ack_i,
  output logic                   hold_flag_o
);

  // Last BUSY cycle index before forced completion
  localparam logic [RibTimeoutW-1:0] TermCnt =
    RibTimeoutW'(TIMEOUT_CYC - 1);

  logic [1:0]             state_q, state_d;
  logic [NUM_M-1:0]       grant_q, grant_d;
  logic [RibTimeoutW-1:0] cnt_q, cnt_d;
  logic                   sreq_q, sreq_d;
  logic                   swe_q, swe_d;
  logic [DataW-1:0]       saddr_q, saddr_d;
  logic [DataW-1:0]       swdata_q, swdata_d;
  logic [DataW-1:0]       rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_M-1:0]       pe_gnt;
  logic                   pe_vld;
  logic                   sel_we;
  logic [DataW-1:0]       sel_addr;
  logic [DataW-1:0]       sel_wdata;
  logic                   fin;

  rib_prio_enc #(
    .N(NUM_M)
  ) u_prio (
    .req_i(m_req_i),
    .gnt_o(pe_gnt),
    .vld_o(pe_vld)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pe_gnt[i]) begin
        sel_we    = sel_we | m_we_i[i];
        sel_addr  = sel_addr | m_addr_i[DataW*i +: DataW];
        sel_wdata = sel_wdata | m_wdata_i[DataW*i +: DataW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    sreq_d   = sreq_q;
    swe_d    = swe_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    fin      = 1'b0;
    unique case (state_q)
      RibIdle: begin
        if (pe_vld) begin
          state_d  = RibBusy;
          grant_d  = pe_gnt;
          cnt_d    = '0;
          sreq_d   = 1'b1;
          swe_d    = sel_we;
          saddr_d  = sel_addr;
          swdata_d = sel_wdata;
        end
      end
      RibBusy: begin
        // A late ack on the terminal cycle still wins
        if (s_ack_i) begin
          fin     = 1'b1;
          rdata_d = s_rdata_i;
          err_d   = 1'b0;
        end else if (cnt_q == TermCnt) begin
          fin     = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (fin) begin
          state_d  = RibDone;
          sreq_d   = 1'b0;
          swe_d    = 1'b0;
          saddr_d  = '0;
          swdata_d = '0;
        end
      end
      RibDone: begin
        state_d = RibIdle;
        grant_d = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = RibIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RibIdle;
      grant_q  <= '0;
      cnt_q    <= '0;
      sreq_q   <= 1'b0;
      swe_q    <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      sreq_q   <= sreq_d;
      swe_q    <= swe_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign grant_o   = grant_q;
  assign s_req_o   = sreq_q;
  assign s_we_o    = swe_q;
  assign s_addr_o  = saddr_q;
  assign s_wdata_o = swdata_q;
  assign m_rdata_o = rdata_q;
  assign m_err_o   = err_q;
  assign m_ack_o   = (state_q == RibDone) ? grant_q : '0;

  // In IDLE the stall is raised early from the raw requests
  assign hold_flag_o = rst & ((state_q == RibIdle)
                       ? |(m_req_i & HOLD_MASK)
                       : |(grant_q & HOLD_MASK));

endmodule
